// File: rtl/pin_sampler_if.sv
// rtl/pin_sampler_if.sv - event queue handshake between pin_sampler and its consumer
// master: pin_sampler drives evt_valid/evt_chan/evt_rise and samples evt_ready
// slave : consumer drives evt_ready and samples the head event
interface pin_sampler_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_chan;
    logic       evt_rise;

    modport master (output evt_valid, output evt_chan, output evt_rise, input evt_ready);
    modport slave  (input evt_valid, input evt_chan, input evt_rise, output evt_ready);
endinterface

// File: rtl/pin_sampler.sv
// rtl/pin_sampler.sv - per-channel pad sampler, debouncer and level-change event queue
// Build option: PIN_SAMPLER_SYNC_EN selects a two-flop synchroniser (default: one register stage).
// Ports:
//   clk, resetn        system clock, synchronous active-low reset
//   pin_di[WIDTH]      raw pad inputs (asynchronous to clk)
//   sample_en[WIDTH]   1 = pad released, channel may be sampled
//   level[WIDTH]       debounced pad levels
//   ovf / ovf_clr      sticky lost-event flag and its clear
//   evt                event queue head (valid/ready, chan, rise)
module pin_sampler #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 24000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WIDTH-1:0]  pin_di,
    input  logic [WIDTH-1:0]  sample_en,
    output logic [WIDTH-1:0]  level,
    output logic              ovf,
    input  logic              ovf_clr,
    pin_sampler_if.master     evt
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    // ---------------- sample stage ----------------
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s;

`ifdef PIN_SAMPLER_SYNC_EN
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pin_di;
            s2_q <= s1_q;
        end
    end

    assign s = s2_q;
`else
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q <= '0;
        end else begin
            s1_q <= pin_di;
        end
    end

    assign s = s1_q;
`endif

    // ---------------- state ----------------
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] pdir_q, pdir_d;
    logic             ovf_q, ovf_d;

    logic [2:0]       mem_chan_q [4];
    logic             mem_rise_q [4];
    logic [1:0]       wr_q, wr_d;
    logic [1:0]       rd_q, rd_d;
    logic [2:0]       qcnt_q, qcnt_d;
    logic [2:0]       last_chan_q;
    logic             last_rise_q;

    logic             any_pend;
    logic [WIDTH-1:0] sel_oh;
    logic [2:0]       sel_chan;
    logic             sel_rise;
    logic             q_empty, q_full;
    logic             push, pop;
    logic             collision;

    // ---------------- debounce ----------------
    always_comb begin
        level_d = level_q;
        tog     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!sample_en[i]) begin
                cnt_d[i] = '0;
            end else if (s[i] == level_q[i]) begin
                // one agreeing sample restarts the count: glitch rejection
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
                tog[i]     = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // ---------------- arbiter + pending ----------------
    assign q_empty = (qcnt_q == 3'd0);
    assign q_full  = (qcnt_q == 3'd4);
    assign pop     = !q_empty && evt.evt_ready;

    always_comb begin
        any_pend = 1'b0;
        sel_oh   = '0;
        sel_chan = '0;
        sel_rise = 1'b0;
        // descending scan so the lowest pending index is the one left selected
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                any_pend = 1'b1;
                sel_oh   = '0;
                sel_oh[i] = 1'b1;
                sel_chan = 3'(i);
                sel_rise = pdir_q[i];
            end
        end
    end

    // a full queue still accepts when the head leaves in the same cycle
    assign push = any_pend && (!q_full || pop);

    always_comb begin
        pend_d    = pend_q;
        pdir_d    = pdir_q;
        collision = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tog[i]) begin
                // still pending and not leaving this cycle: old event is lost
                if (pend_q[i] && !(push && sel_oh[i])) begin
                    collision = 1'b1;
                end
                pend_d[i] = 1'b1;
                pdir_d[i] = level_d[i];
            end else if (push && sel_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        if (collision) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // ---------------- queue ----------------
    always_comb begin
        wr_d = push ? wr_q + 2'd1 : wr_q;
        rd_d = pop  ? rd_q + 2'd1 : rd_q;
        case ({push, pop})
            2'b10:   qcnt_d = qcnt_q + 3'd1;
            2'b01:   qcnt_d = qcnt_q - 3'd1;
            default: qcnt_d = qcnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < 4; j++) begin
                mem_chan_q[j] <= '0;
                mem_rise_q[j] <= 1'b0;
            end
            level_q     <= '0;
            pend_q      <= '0;
            pdir_q      <= '0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            qcnt_q      <= '0;
            last_chan_q <= '0;
            last_rise_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (push) begin
                mem_chan_q[wr_q] <= sel_chan;
                mem_rise_q[wr_q] <= sel_rise;
            end
            // remember the departing head so the outputs hold once empty
            if (pop) begin
                last_chan_q <= mem_chan_q[rd_q];
                last_rise_q <= mem_rise_q[rd_q];
            end
            level_q <= level_d;
            pend_q  <= pend_d;
            pdir_q  <= pdir_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            qcnt_q  <= qcnt_d;
        end
    end

    assign evt.evt_valid = !q_empty;
    assign evt.evt_chan  = q_empty ? last_chan_q : mem_chan_q[rd_q];
    assign evt.evt_rise  = q_empty ? last_rise_q : mem_rise_q[rd_q];
    assign level         = level_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_pin_sampler.sv
// tb/tb_pin_sampler.sv - directed self-checking bench for pin_sampler (WIDTH=4, DEBOUNCE=4)
module tb_pin_sampler;

`ifdef PIN_SAMPLER_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] pin_di;
    logic [3:0] sample_en;
    logic [3:0] level;
    logic       ovf;
    logic       ovf_clr;

    pin_sampler_if evt_if ();

    pin_sampler #(.WIDTH(4), .DEBOUNCE(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pin_di    (pin_di),
        .sample_en (sample_en),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [2:0] log_chan [$];
    logic       log_rise [$];
    int         log_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && evt_if.evt_valid && evt_if.evt_ready) begin
            log_chan.push_back(evt_if.evt_chan);
            log_rise.push_back(evt_if.evt_rise);
            log_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input int idx, input int ch, input int r);
        chk({tag, " present"}, 32'(idx < log_chan.size()), 1);
        if (idx < log_chan.size()) begin
            chk({tag, " chan"}, 32'(log_chan[idx]), ch);
            chk({tag, " rise"}, 32'(log_rise[idx]), r);
        end
    endtask

    task automatic clear_log();
        log_chan.delete();
        log_rise.delete();
        log_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        resetn           = 1'b0;
        pin_di           = 4'b0000;
        sample_en        = 4'b1111;
        ovf_clr          = 1'b0;
        evt_if.evt_ready = 1'b1;
        tick(2);
        chk("reset level", 32'(level), 0);
        chk("reset valid", 32'(evt_if.evt_valid), 0);
        chk("reset chan", 32'(evt_if.evt_chan), 0);
        chk("reset rise", 32'(evt_if.evt_rise), 0);
        chk("reset ovf", 32'(ovf), 0);
        resetn = 1'b1;
        tick(3);

        // single rise on channel 2
        clear_log();
        pin_di[2] = 1'b1;
        tick(SL + 3);
        chk("rise level before", 32'(level), 0);
        tick(1);
        chk("rise level after", 32'(level), 4'b0100);
        chk("rise valid early", 32'(evt_if.evt_valid), 0);
        tick(1);
        chk("rise valid", 32'(evt_if.evt_valid), 1);
        chk("rise head chan", 32'(evt_if.evt_chan), 2);
        chk("rise head rise", 32'(evt_if.evt_rise), 1);
        tick(1);
        chk("rise popped", 32'(evt_if.evt_valid), 0);
        chk("rise hold chan", 32'(evt_if.evt_chan), 2);
        chk("rise hold rise", 32'(evt_if.evt_rise), 1);
        tick(5);
        chk("rise count", 32'(log_chan.size()), 1);
        check_evt("rise evt", 0, 2, 1);

        // glitch rejection on channel 0
        clear_log();
        pin_di[0] = 1'b1;
        tick(3);
        pin_di[0] = 1'b0;
        tick(1);
        pin_di[0] = 1'b1;
        for (int i = 0; i < SL + 3; i++) begin
            tick(1);
            chk("glitch hold", 32'(level[0]), 0);
        end
        tick(1);
        chk("glitch level", 32'(level), 4'b0101);
        tick(6);
        chk("glitch count", 32'(log_chan.size()), 1);
        check_evt("glitch evt", 0, 0, 1);

        // masking on channel 1
        clear_log();
        sample_en[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pin_di[1] = ~pin_di[1];
            tick(1);
        end
        pin_di[1] = 1'b1;
        tick(5);
        chk("mask level", 32'(level), 4'b0101);
        chk("mask no events", 32'(log_chan.size()), 0);
        sample_en[1] = 1'b1;
        tick(3);
        chk("unmask level before", 32'(level), 4'b0101);
        tick(1);
        chk("unmask level after", 32'(level), 4'b0111);
        tick(6);
        chk("unmask count", 32'(log_chan.size()), 1);
        check_evt("unmask evt", 0, 1, 1);

        // simultaneous channels: all fall, then all rise
        clear_log();
        pin_di = 4'b0000;
        tick(SL + 10);
        chk("simfall count", 32'(log_chan.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check_evt("simfall evt", i, i, 0);
        end
        clear_log();
        pin_di = 4'b1111;
        tick(SL + 10);
        chk("simrise level", 32'(level), 4'b1111);
        chk("simrise count", 32'(log_chan.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check_evt("simrise evt", i, i, 1);
            if (i < log_cyc.size()) begin
                chk("simrise consecutive", 32'(log_cyc[i] - log_cyc[0]), i);
            end
        end
        chk("simrise ovf", 32'(ovf), 0);

        // backpressure and overflow
        clear_log();
        evt_if.evt_ready = 1'b0;
        pin_di = 4'b0000;
        tick(SL + 10);
        chk("bp level", 32'(level), 0);
        chk("bp valid", 32'(evt_if.evt_valid), 1);
        chk("bp head chan", 32'(evt_if.evt_chan), 0);
        chk("bp head rise", 32'(evt_if.evt_rise), 0);
        tick(3);
        chk("bp held valid", 32'(evt_if.evt_valid), 1);
        chk("bp held chan", 32'(evt_if.evt_chan), 0);
        pin_di = 4'b1000;
        tick(SL + 6);
        chk("bp ch3 up", 32'(level), 4'b1000);
        chk("bp ovf before", 32'(ovf), 0);
        pin_di = 4'b0000;
        tick(SL + 6);
        chk("bp ch3 down", 32'(level), 0);
        chk("bp ovf set", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("bp ovf clr", 32'(ovf), 0);
        chk("bp no pops", 32'(log_chan.size()), 0);
        evt_if.evt_ready = 1'b1;
        tick(12);
        chk("bp drain count", 32'(log_chan.size()), 5);
        for (int i = 0; i < 4; i++) begin
            check_evt("bp drain evt", i, i, 0);
        end
        check_evt("bp latest evt", 4, 3, 0);
        chk("bp drained", 32'(evt_if.evt_valid), 0);

        // reset mid-operation with two events queued
        clear_log();
        evt_if.evt_ready = 1'b0;
        pin_di = 4'b0011;
        tick(SL + 8);
        chk("mid level", 32'(level), 4'b0011);
        chk("mid valid", 32'(evt_if.evt_valid), 1);
        resetn = 1'b0;
        pin_di = 4'b0000;
        tick(1);
        resetn = 1'b1;
        chk("mid reset valid", 32'(evt_if.evt_valid), 0);
        chk("mid reset level", 32'(level), 0);
        chk("mid reset ovf", 32'(ovf), 0);
        evt_if.evt_ready = 1'b1;
        tick(SL + 10);
        chk("mid after valid", 32'(evt_if.evt_valid), 0);
        chk("mid after level", 32'(level), 0);
        chk("mid no stale", 32'(log_chan.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
